// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants, parity helper.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int TICK_W      = $clog2(OVERSAMPLE);
  localparam int SAMPLE_TICK = OVERSAMPLE / 2 - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Unused data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_rd;
  logic             do_wr;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_fifo.sv
// UART with 16x oversampling and RX/TX FIFOs.
// Define UART_PARITY_EN to add a parity bit (odd/even via parity_odd) to every frame.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int freq_hz    = 50000000,
  parameter int baud       = 115200,
  parameter int data_bits  = 8,
  parameter int fifo_depth = 16,
  parameter int parity_odd = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       rx_error,
  output logic       rx_overflow
);

  localparam int          DIVISOR  = freq_hz / (OVERSAMPLE * baud);
  localparam int          DIV_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [2:0]  LAST_BIT = 3'(data_bits - 1);

  // ---------------- prescaler ----------------
  logic [DIV_W-1:0] presc_q;
  logic             tick;

  assign tick = (presc_q == DIV_W'(DIVISOR - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  // ---------------- transmitter ----------------
  uart_state_e          tx_state_q;
  logic [TICK_W-1:0]    tx_tick_q;
  logic [2:0]           tx_bit_q;
  logic [data_bits-1:0] tx_shift_q;
  logic                 txd_q;
  logic [data_bits-1:0] tx_head;
  logic                 tx_empty;
  logic                 tx_pop;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_pop   = tick && (tx_state_q == ST_IDLE) && !tx_empty;
  assign tx_busy  = !tx_empty || (tx_state_q != ST_IDLE);
  assign uart_txd = txd_q;

  uart_sync_fifo #(.width(data_bits), .depth(fifo_depth)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en_i   (tx_wr),
    .wr_data_i (tx_data[data_bits-1:0]),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_head),
    .full_o    (tx_full),
    .empty_o   (tx_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= ST_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else if (tick) begin
      if (tx_state_q == ST_IDLE) begin
        if (!tx_empty) begin
          tx_shift_q <= tx_head;
          txd_q      <= 1'b0;
          tx_tick_q  <= '0;
          tx_state_q <= ST_START;
`ifdef UART_PARITY_EN
          tx_par_q   <= parity_bit(8'(tx_head), parity_odd != 0);
`endif
        end
      end else begin
        tx_tick_q <= tx_tick_q + 1'b1;
        if (tx_tick_q == TICK_W'(OVERSAMPLE - 1)) begin
          case (tx_state_q)
            ST_START: begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= '0;
              tx_state_q <= ST_DATA;
            end
            ST_DATA: begin
              if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                txd_q      <= tx_par_q;
                tx_state_q <= ST_PARITY;
`else
                txd_q      <= 1'b1;
                tx_state_q <= ST_STOP;
`endif
              end else begin
                txd_q      <= tx_shift_q[0];
                tx_shift_q <= tx_shift_q >> 1;
                tx_bit_q   <= tx_bit_q + 1'b1;
              end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
              txd_q      <= 1'b1;
              tx_state_q <= ST_STOP;
            end
`endif
            default: tx_state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // ---------------- receiver ----------------
  // Bits [1:0] form the synchroniser; bit 2 is the previous synchronised value for edge detect.
  logic [2:0]           rx_sync_q;
  logic                 rxd_s;
  uart_state_e          rx_state_q;
  logic [TICK_W-1:0]    rx_tick_q;
  logic [2:0]           rx_bit_q;
  logic [data_bits-1:0] rx_shift_q;
  logic                 rx_push_q;
  logic                 rx_err_q;
  logic                 rx_ovf_q;
  logic                 rx_bad_par;
  logic [data_bits-1:0] rx_head;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_pop;

  assign rxd_s       = rx_sync_q[1];
  assign rx_avail    = !rx_empty;
  assign rx_pop      = rx_ack && rx_avail;
  assign rx_data     = rx_avail ? 8'(rx_head) : 8'h00;
  assign rx_error    = rx_err_q;
  assign rx_overflow = rx_ovf_q;

`ifdef UART_PARITY_EN
  logic rx_par_err_q;
  assign rx_bad_par = rx_par_err_q;
`else
  logic cfg_unused;
  assign cfg_unused = (parity_odd != 0);
  assign rx_bad_par = 1'b0;
`endif

  uart_sync_fifo #(.width(data_bits), .depth(fifo_depth)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en_i   (rx_push_q),
    .wr_data_i (rx_shift_q),
    .rd_en_i   (rx_pop),
    .rd_data_o (rx_head),
    .full_o    (rx_full),
    .empty_o   (rx_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_sync_q <= '1;
    else          rx_sync_q <= {rx_sync_q[1:0], uart_rxd};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q   <= ST_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_push_q    <= 1'b0;
      rx_err_q     <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      rx_push_q <= 1'b0;
      rx_err_q  <= 1'b0;
      if (rx_state_q == ST_IDLE) begin
        if (rx_sync_q[2] && !rxd_s) begin
          rx_state_q   <= ST_START;
          rx_tick_q    <= '0;
`ifdef UART_PARITY_EN
          rx_par_err_q <= 1'b0;
`endif
        end
      end else if (tick) begin
        rx_tick_q <= rx_tick_q + 1'b1;
        if (rx_tick_q == TICK_W'(SAMPLE_TICK)) begin
          case (rx_state_q)
            ST_START: if (rxd_s) rx_state_q <= ST_IDLE;
            ST_DATA:  rx_shift_q <= {rxd_s, rx_shift_q[data_bits-1:1]};
`ifdef UART_PARITY_EN
            ST_PARITY: rx_par_err_q <= (rxd_s != parity_bit(8'(rx_shift_q), parity_odd != 0));
`endif
            ST_STOP: begin
              // Return to IDLE mid-stop so the next start edge is never missed.
              rx_state_q <= ST_IDLE;
              if (!rxd_s || rx_bad_par) rx_err_q  <= 1'b1;
              else                      rx_push_q <= 1'b1;
            end
            default: ;
          endcase
        end else if (rx_tick_q == TICK_W'(OVERSAMPLE - 1)) begin
          case (rx_state_q)
            ST_START: begin
              rx_bit_q   <= '0;
              rx_state_q <= ST_DATA;
            end
            ST_DATA: begin
              if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                rx_state_q <= ST_PARITY;
`else
                rx_state_q <= ST_STOP;
`endif
              end else begin
                rx_bit_q <= rx_bit_q + 1'b1;
              end
            end
            ST_PARITY: rx_state_q <= ST_STOP;
            default: ;
          endcase
        end
      end
    end
  end

  // Sticky; a pop in the same cycle makes room, so that case is not an overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                rx_ovf_q <= 1'b0;
    else if (rx_push_q && rx_full && !rx_pop)    rx_ovf_q <= 1'b1;
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo; honours UART_PARITY_EN when defined.
module tb_uart_fifo;

  // divisor = 10e6 / (16*115200) = 5 (5.43 truncated); one bit = 16*5 = 80 cycles
  localparam int FREQ     = 10_000_000;
  localparam int BAUD     = 115200;
  localparam int BIT_CYC  = 80;
  localparam int HALF_BIT = 40;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       reset_n;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_ack;
  logic       rx_error;
  logic       rx_overflow;

  logic loop_en;
  logic rxd_drv;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  uart_fifo #(
    .freq_hz    (FREQ),
    .baud       (BAUD),
    .data_bits  (8),
    .fifo_depth (16),
    .parity_odd (0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_rxd    (uart_rxd),
    .uart_txd    (uart_txd),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .rx_avail    (rx_avail),
    .rx_ack      (rx_ack),
    .rx_error    (rx_error),
    .rx_overflow (rx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with rx_error high, so a one-cycle pulse adds exactly 1.
  always @(negedge clk) if (rx_error === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic rx_pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_avail"}, rx_avail, 1);
    check({tag, "_data"}, rx_data, exp);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Frame bit order: start, d[0..7], parity (even, optionally flipped), stop.
  task automatic send_char(input logic [7:0] d, input logic stop_b, input logic bad_par);
    logic [10:0] frame;
    frame = {stop_b, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
`ifndef UART_PARITY_EN
      if (i == 9) continue;
`endif
      rxd_drv = frame[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  task automatic wait_txd_fall(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (uart_txd == 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_tx_idle(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (tx_busy == 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [10:0] a5_bits;
    int          e0;

`ifdef UART_PARITY_EN
    a5_bits = 11'b1_0_10100101_0;
`else
    a5_bits = 11'b0_1_10100101_0;
`endif
    reset_n = 1'b0;
    rxd_drv = 1'b1;
    loop_en = 1'b0;
    tx_data = 8'h00;
    tx_wr   = 1'b0;
    rx_ack  = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_avail", rx_avail, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_error", rx_error, 0);
    check("rst_rx_overflow", rx_overflow, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // ---- transmit 0xA5 and check the waveform bit by bit ----
    tx_write(8'hA5);
    check("a5_busy", tx_busy, 1);
    wait_txd_fall(50, seen);
    check("a5_start_seen", seen, 1);
    repeat (HALF_BIT) @(negedge clk);
    for (int i = 0; i < NBITS; i++) begin
      if (i > 0) repeat (BIT_CYC) @(negedge clk);
      check($sformatf("a5_bit%0d", i), uart_txd, a5_bits[i]);
    end
    check("a5_busy_in_stop", tx_busy, 1);
    repeat (HALF_BIT + 5) @(negedge clk);
    check("a5_busy_done", tx_busy, 0);

    // ---- loopback of 0x00, 0xFF, 0x55 ----
    loop_en = 1'b1;
    e0 = err_cnt;
    tx_write(8'h00);
    tx_write(8'hFF);
    tx_write(8'h55);
    wait_tx_idle(4000, seen);
    check("loop_tx_done", seen, 1);
    repeat (5) @(negedge clk);
    rx_pop_check("loop0", 8'h00);
    rx_pop_check("loop1", 8'hFF);
    rx_pop_check("loop2", 8'h55);
    check("loop_empty", rx_avail, 0);
    check("loop_no_err", err_cnt - e0, 0);
    loop_en = 1'b0;
    repeat (BIT_CYC) @(negedge clk);

    // ---- framing error: 0x3C with stop bit 0 ----
    e0 = err_cnt;
    send_char(8'h3C, 1'b0, 1'b0);
    check("frm_err_pulse", err_cnt - e0, 1);
    check("frm_no_avail", rx_avail, 0);

`ifdef UART_PARITY_EN
    // ---- parity: 0x07 needs parity bit 1 under even parity ----
    e0 = err_cnt;
    send_char(8'h07, 1'b1, 1'b1);
    check("par_bad_err", err_cnt - e0, 1);
    check("par_bad_no_avail", rx_avail, 0);
    e0 = err_cnt;
    send_char(8'h07, 1'b1, 1'b0);
    check("par_good_no_err", err_cnt - e0, 0);
    rx_pop_check("par_good", 8'h07);
`endif

    // ---- overflow: 17 characters into a 16-deep RX FIFO ----
    e0 = err_cnt;
    for (int i = 0; i < 17; i++) begin
      send_char(8'(i * 13 + 2), 1'b1, 1'b0);
      if (i == 15) check("ovf_clear_at_16", rx_overflow, 0);
    end
    check("ovf_set", rx_overflow, 1);
    check("ovf_no_err", err_cnt - e0, 0);
    for (int i = 0; i < 16; i++) rx_pop_check($sformatf("ovf%0d", i), 8'(i * 13 + 2));
    check("ovf_17th_lost", rx_avail, 0);
    check("ovf_sticky", rx_overflow, 1);

    // ---- TX FIFO full boundary, then reset during data bit 3 ----
    tx_write(8'h00);
    wait_txd_fall(50, seen);
    check("rst_tx_start_seen", seen, 1);
    for (int i = 0; i < 16; i++) begin
      tx_write(8'h11);
      if (i == 14) check("tx_not_full_15", tx_full, 0);
    end
    check("tx_full_16", tx_full, 1);
    tx_write(8'h22);
    check("tx_full_after_drop", tx_full, 1);
    repeat (HALF_BIT + 4 * BIT_CYC - 18) @(negedge clk);
    check("bit3_low", uart_txd, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_txd", uart_txd, 1);
    check("arst_tx_busy", tx_busy, 0);
    check("arst_tx_full", tx_full, 0);
    check("arst_rx_overflow", rx_overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_txd", uart_txd, 1);
    check("post_rst_fifo_empty", tx_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
